// File: rtl/mac_pkg.sv
// Shared constants and the feeder state type for the fixed-point MAC and its front end.
package mac_pkg;
  localparam int W        = 16;
  localparam int Q_DEC    = 9;
  localparam int PIPE_LAT = 3;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8001;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    CLR,
    STREAM,
    FLUSH,
    CAPT,
    DONE
  } feeder_state_t;
endpackage

// File: rtl/mac_feeder_opmem.sv
// Dual operand vector register file: one synchronous write port, one combinational indexed read.
module mac_feeder_opmem #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_a,
  input  logic [W-1:0]  wr_b,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_a,
  output logic [W-1:0]  rd_b
);
  logic [W-1:0] mem_a [DEPTH];
  logic [W-1:0] mem_b [DEPTH];

  // Contents survive reset on purpose; the host reloads only what changes.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_a[wr_addr] <= wr_a;
      mem_b[wr_addr] <= wr_b;
    end
  end

  assign rd_a = mem_a[rd_addr];
  assign rd_b = mem_b[rd_addr];
endmodule

// File: rtl/mac_feeder.sv
// Dot-product front end: primes/clears the MAC, streams len operand pairs, flushes, returns ACC.
// Optional MAC_FEEDER_SAT_FLAG_EN adds res_sat, flagging a saturated captured result.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int W         = mac_pkg::W,
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int PIPE_LAT  = mac_pkg::PIPE_LAT,
  parameter int PRIME_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_a,
  input  logic [W-1:0]  wr_b,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          mac_rst,
  output logic          mac_en,
  output logic [W-1:0]  mac_a,
  output logic [W-1:0]  mac_b,
  input  logic [W-1:0]  mac_acc,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output feeder_state_t state_dbg
`ifdef MAC_FEEDER_SAT_FLAG_EN
  ,
  output logic          res_sat
`endif
);
  localparam int CMAX = (PRIME_CYC > PIPE_LAT) ? PRIME_CYC : PIPE_LAT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);

  // Result handshake: res_data is meaningful while res_valid=1 and is held
  // stable until the cycle where res_valid && res_ready, after which it retires.
  feeder_state_t state, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          busy_d, mac_rst_d, mac_en_d, res_valid_d;
  logic [W-1:0]  mac_a_d, mac_b_d, res_data_d;
  logic [W-1:0]  rd_a, rd_b;
  logic          accept, we;
`ifdef MAC_FEEDER_SAT_FLAG_EN
  logic          res_sat_d;
`endif

  assign accept    = (state == IDLE) && start && (len != '0) && (len <= MAX_LEN);
  assign we        = wr_en && (state == IDLE) && !accept;
  assign state_dbg = state;

  mac_feeder_opmem #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_opmem (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_a    (wr_a),
    .wr_b    (wr_b),
    .rd_addr (idx[AW-1:0]),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

  // Outputs are registered as a function of the state being entered, so each
  // branch sets the pin values for the cycle that follows the transition.
  // idx runs one ahead: it addresses the pair to present at the next edge.
  always_comb begin
    state_d     = state;
    len_d       = len_q;
    idx_d       = idx;
    cnt_d       = cnt;
    busy_d      = busy;
    mac_rst_d   = 1'b0;
    mac_en_d    = 1'b0;
    mac_a_d     = '0;
    mac_b_d     = '0;
    res_valid_d = res_valid;
    res_data_d  = res_data;
`ifdef MAC_FEEDER_SAT_FLAG_EN
    res_sat_d   = res_sat;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d  = PRIME;
          len_d    = len;
          cnt_d    = CW'(PRIME_CYC - 1);
          busy_d   = 1'b1;
          mac_en_d = 1'b1;
        end
      end
      PRIME: begin
        if (cnt == '0) begin
          state_d   = CLR;
          mac_rst_d = 1'b1;
          idx_d     = '0;
        end else begin
          cnt_d    = cnt - 1'b1;
          mac_en_d = 1'b1;
        end
      end
      CLR: begin
        state_d  = STREAM;
        mac_en_d = 1'b1;
        mac_a_d  = rd_a;
        mac_b_d  = rd_b;
        idx_d    = idx + 1'b1;
      end
      STREAM: begin
        mac_en_d = 1'b1;
        if (idx == len_q) begin
          state_d = FLUSH;
          cnt_d   = CW'(PIPE_LAT);
        end else begin
          mac_a_d = rd_a;
          mac_b_d = rd_b;
          idx_d   = idx + 1'b1;
        end
      end
      FLUSH: begin
        if (cnt == '0) begin
          state_d = CAPT;
        end else begin
          cnt_d    = cnt - 1'b1;
          mac_en_d = 1'b1;
        end
      end
      CAPT: begin
        state_d     = DONE;
        res_valid_d = 1'b1;
        res_data_d  = mac_acc;
`ifdef MAC_FEEDER_SAT_FLAG_EN
        res_sat_d   = (mac_acc == SAT_POS) || (mac_acc == SAT_NEG);
`endif
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
`ifdef MAC_FEEDER_SAT_FLAG_EN
          res_sat_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      idx       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      mac_rst   <= 1'b1;
      mac_en    <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
`ifdef MAC_FEEDER_SAT_FLAG_EN
      res_sat   <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      len_q     <= len_d;
      idx       <= idx_d;
      cnt       <= cnt_d;
      busy      <= busy_d;
      mac_rst   <= mac_rst_d;
      mac_en    <= mac_en_d;
      mac_a     <= mac_a_d;
      mac_b     <= mac_b_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
`ifdef MAC_FEEDER_SAT_FLAG_EN
      res_sat   <= res_sat_d;
`endif
    end
  end
endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: behavioural MAC on the pins, dot-product reference, randomized runs.
module tb_mac_feeder;
  import mac_pkg::*;

  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int PRIME_CYC = 2;

  // ---------------- clock / reset / pins ----------------
  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          wr_en     = 1'b0;
  logic [AW-1:0] wr_addr   = '0;
  logic [W-1:0]  wr_a      = '0;
  logic [W-1:0]  wr_b      = '0;
  logic          start     = 1'b0;
  logic [AW:0]   len       = '0;
  logic          res_ready = 1'b0;
  logic          busy, mac_rst, mac_en, res_valid;
  logic [W-1:0]  mac_a, mac_b, mac_acc, res_data;
  feeder_state_t state_dbg;
`ifdef MAC_FEEDER_SAT_FLAG_EN
  logic          res_sat;
`endif

  always #5 clk = ~clk;

  mac_feeder #(
    .W(W), .DEPTH(DEPTH), .AW(AW), .PIPE_LAT(PIPE_LAT), .PRIME_CYC(PRIME_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_a      (wr_a),
    .wr_b      (wr_b),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .mac_rst   (mac_rst),
    .mac_en    (mac_en),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_acc   (mac_acc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .state_dbg (state_dbg)
`ifdef MAC_FEEDER_SAT_FLAG_EN
    ,
    .res_sat   (res_sat)
`endif
  );

  // ---------------- fixed-point arithmetic ----------------
  function automatic int qmul(input logic [W-1:0] a, input logic [W-1:0] b);
    return (int'($signed(a)) * int'($signed(b))) >>> Q_DEC;
  endfunction

  function automatic int sat_add(input int acc, input int p);
    int s;
    s = acc + p;
    if (s > 32767) return 32767;
    if (s < -32767) return -32767;
    return s;
  endfunction

  // ---------------- MAC model on the pins ----------------
  // Operand stage, product stage, accumulator; stages start with junk so a
  // missing prime corrupts the sum. rst clears only the accumulator.
  logic [W-1:0] stg_a = 16'h3A00;
  logic [W-1:0] stg_b = 16'h0C40;
  int           stg_p = 1234;
  int           acc_v = 0;

  always @(posedge clk) begin
    if (mac_rst) begin
      acc_v <= 0;
    end else if (mac_en) begin
      acc_v <= sat_add(acc_v, stg_p);
      stg_p <= qmul(stg_a, stg_b);
      stg_a <= mac_a;
      stg_b <= mac_b;
    end
  end
  assign mac_acc = W'(acc_v);

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0]   ma [DEPTH];
  logic [W-1:0]   mb [DEPTH];
  logic [2*W-1:0] exp_q [$];
  logic [2*W-1:0] obs_q [$];
  int bad_len [3] = '{0, 17, 31};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int dot(input int n);
    int acc;
    acc = 0;
    for (int i = 0; i < n; i++) acc = sat_add(acc, qmul(ma[i], mb[i]));
    return acc;
  endfunction

  function automatic logic [W-1:0] rand_op();
    return W'(int'($urandom_range(0, 2047)) - 1024);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic write_op(input int addr, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_a = a; wr_b = b;
    @(negedge clk);
    wr_en = 1'b0;
    ma[addr] = a;
    mb[addr] = b;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) write_op(i, rand_op(), rand_op());
  endtask

  // poke: 0 none, 1 write alongside start, 2 write while busy (both must be dropped)
  // exp_ov: forced expected result, or -1 to use the dot-product reference
  task automatic run(input int n, input int hold, input int poke, input int exp_ov);
    int cyc;
    int pulses;
    int errs;
    logic [W-1:0] exp_res;
    exp_res = (exp_ov >= 0) ? W'(exp_ov) : W'(dot(n));
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < PRIME_CYC; i++) exp_q.push_back('0);
    for (int i = 0; i < n; i++) exp_q.push_back({ma[i], mb[i]});
    for (int i = 0; i <= PIPE_LAT; i++) exp_q.push_back('0);

    @(negedge clk);
    start = 1'b1; len = (AW+1)'(n); res_ready = (hold == 0);
    if (poke == 1) begin
      wr_en = 1'b1; wr_addr = '0; wr_a = ~ma[0]; wr_b = ~mb[0];
    end
    cyc = 0;
    pulses = 0;
    while (cyc < 64) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      wr_en = 1'b0;
      if (cyc == 1) check("busy_set", busy, 1);
      if (poke == 2 && cyc == 6) begin
        wr_en = 1'b1; wr_addr = '0; wr_a = ~ma[0]; wr_b = ~mb[0];
      end
      if (mac_rst) pulses++;
      if (mac_en) obs_q.push_back({mac_a, mac_b});
      if (res_valid) break;
    end
    wr_en = 1'b0;

    check("res_valid", res_valid, 1);
    check("latency", cyc - 1, PRIME_CYC + 1 + n + PIPE_LAT + 2);
    check("res_data", res_data, exp_res);
    check("rst_pulse", pulses, 1);
    errs = 0;
    if (obs_q.size() != exp_q.size()) errs++;
    else foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) errs++;
    check("op_stream", errs, 0);
`ifdef MAC_FEEDER_SAT_FLAG_EN
    check("res_sat", res_sat, (exp_res == SAT_POS) || (exp_res == SAT_NEG));
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, exp_res);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("valid_drop", res_valid, 0);
    check("busy_drop", busy, 0);
    check("back_idle", state_dbg, IDLE);
`ifdef MAC_FEEDER_SAT_FLAG_EN
    check("sat_clear", res_sat, 0);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mac_rst"}, mac_rst, 1);
    check({tag, "_mac_en"}, mac_en, 0);
    check({tag, "_mac_a"}, mac_a, 0);
    check({tag, "_mac_b"}, mac_b, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_state"}, state_dbg, IDLE);
`ifdef MAC_FEEDER_SAT_FLAG_EN
    check({tag, "_res_sat"}, res_sat, 0);
`endif
  endtask

  task automatic reset_mid_stream(input int n);
    @(negedge clk);
    start = 1'b1; len = (AW+1)'(n); res_ready = 1'b0;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_in_stream", state_dbg, STREAM);
    check("mid_en", mac_en, 1);
    rst = 1'b1;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench stalled");
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst = 1'b0;
    @(negedge clk);
    check("idle_mac_rst", mac_rst, 0);

    foreach (bad_len[k]) begin
      @(negedge clk);
      start = 1'b1; len = (AW+1)'(bad_len[k]);
      @(negedge clk);
      start = 1'b0;
      check("bad_len_busy", busy, 0);
      check("bad_len_en", mac_en, 0);
    end

    write_op(0, 16'h0200, 16'h0200);
    write_op(1, 16'h0400, 16'h0200);
    run(2, 0, 0, 16'h0600);

    fill_random();
    run(4, 5, 0, -1);
    run(1, 0, 0, -1);
    run(DEPTH, 1, 0, -1);

    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 3; j++) write_op($urandom_range(0, DEPTH - 1), rand_op(), rand_op());
      run($urandom_range(1, DEPTH), $urandom_range(0, 3), r % 3, -1);
    end
    run($urandom_range(1, DEPTH), 0, 0, -1);

    for (int i = 0; i < DEPTH; i++) write_op(i, 16'h7000, 16'h7000);
    run(DEPTH, 0, 0, 16'h7FFF);
    for (int i = 0; i < DEPTH; i++) write_op(i, 16'h7000, 16'h9000);
    run(DEPTH, 2, 0, 16'h8001);

    fill_random();
    reset_mid_stream(10);
    run(10, 0, 0, -1);
    run($urandom_range(1, DEPTH), 1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Initiator/controller for the 16-bit fixed-point MAC (Q-format, 9 fractional bits). It drives the MAC's rst/enable/A/B pins.
- Holds two local operand vectors, written through a simple write port. On start it primes and clears the MAC, then streams N operand pairs.
- It then flushes the MAC pipeline with zero operands and returns the accumulated result over a valid/ready handshake.
- Sits between the host/sequencer and the MAC instance, as the dot-product front end.

Parameters:
- W, 16, operand and result width
- DEPTH, 16, entries per operand vector
- AW, 4, address/length width (log2 DEPTH)
- PIPE_LAT, 3, MAC enable-to-accumulator latency in enabled cycles
- PRIME_CYC, 2, zero-operand enabled cycles before clearing the MAC

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  operand write strobe; ignored while busy=1
- wr_addr  in  AW  operand write address
- wr_a  in  W  operand A data
- wr_b  in  W  operand B data
- start  in  1  begin a dot product; sampled only in IDLE
- len  in  AW+1  number of pairs, 1..DEPTH; sampled with start
- busy  out  1  high from start acceptance until result handshake completes
- mac_rst  out  1  drives MAC rst
- mac_en  out  1  drives MAC enable
- mac_a  out  W  drives MAC A
- mac_b  out  W  drives MAC B
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  W  accumulated result

Behaviour:
- All outputs are registered. Reset values are: mac_rst=1, mac_en=0, mac_a=0, mac_b=0, busy=0, res_valid=0, res_data=0. State returns to IDLE.
- Reset asserted mid-operation aborts immediately. Operand memory contents are not reset.
- Operand memory is two DEPTH x W register arrays with a synchronous write. The read is combinational by index and feeds the registered mac_a/mac_b.
- IDLE:
  - mac_rst=0, mac_en=0.
  - start=1 with len in 1..DEPTH: latch len, busy=1, go to PRIME.
  - start with len=0 or len>DEPTH: ignored; busy stays 0.
- PRIME: mac_en=1, mac_a=mac_b=0 for PRIME_CYC cycles, so stale MAC internal stages hold zero-operand values. Then go to CLR.
- CLR: mac_rst=1, mac_en=0 for 1 cycle, zeroing the MAC accumulator. Go to STREAM with idx=0.
- STREAM:
  - mac_en=1, mac_a=mem_a[idx], mac_b=mem_b[idx].
  - idx increments each cycle.
  - After the cycle with idx=len-1, go to FLUSH.
- FLUSH: mac_en=1, mac_a=mac_b=0 for PIPE_LAT+1 cycles, so the last product propagates into ACC. Then go to CAPT.
- CAPT: mac_en=0. Sample the MAC ACC_Result (input port mac_acc, W bits, listed with the MAC-side ports) into res_data. Set res_valid=1 and go to DONE.
- DONE:
  - Hold res_valid and res_data stable until res_ready=1.
  - On the handshake cycle: res_valid drops next cycle, busy=0, go to IDLE.
  - res_ready high before res_valid has no effect.
- Total latency from start to res_valid: PRIME_CYC + 1 + len + PIPE_LAT + 2 cycles. Example: len=4 with defaults gives 12.
- start and wr_en while busy=1 are ignored; no queueing.
- A wr_en in the same cycle as an accepted start is ignored.
- idx is AW+1 bits. No wrap-around occurs because len is at most DEPTH.

Optional Feature:
- Macro: MAC_FEEDER_SAT_FLAG_EN.
- When defined, add output res_sat (1 bit, reset 0).
  - Set at CAPT when the captured value is 16'h7FFF or 16'h8001, the MAC saturation codes.
  - Valid alongside res_valid and cleared on handshake.
- When not defined, the port and its logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mac_pkg holds:
  - W and the fractional-bit constant Q_DEC=9
  - saturation constants SAT_POS=16'h7FFF and SAT_NEG=16'h8001
  - PIPE_LAT
  - the state enum feeder_state_t {IDLE, PRIME, CLR, STREAM, FLUSH, CAPT, DONE}
- One natural sub-module: mac_feeder_opmem, the dual-vector operand register file with write port and indexed read.
- The FSM stays in mac_feeder.

Test Plan:
- Write A={1.0=0x0200, 2.0=0x0400}, B={0x0200, 0x0200}, start len=2 -> res_data=0x0600 (3.0), res_valid at cycle 10 after start, busy low one cycle after handshake.
- len=4 with res_ready held low 5 cycles after res_valid -> res_valid and res_data stable throughout; single handshake; returns to IDLE.
- Back-to-back runs with different data -> second result is independent of the first (accumulator cleared); mac_rst pulses exactly once per run.
- Operands 0x7000 x 0x7000 for len=DEPTH -> res_data=0x7FFF; with MAC_FEEDER_SAT_FLAG_EN, res_sat=1.
- start with len=0, then len=17 -> ignored, busy stays 0. wr_en during busy -> memory unchanged (verified on next run).
- rst asserted during STREAM -> all outputs at reset values immediately; a following start completes correctly.
